// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch_queue                                                           |
// | Fetch PC generator, single-outstanding memory port and decode-side FIFO    |
// | with redirect flush. Optional macro: FETCH_BYPASS_EN (same-cycle bypass).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic [31:0] pc_addr
);

    localparam int              PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [31:0]        fetch_pc, fetch_pc_next, issued_pc;
    logic [31:0]        fifo_inst [DEPTH];
    logic [31:0]        fifo_pc   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count, count_next;
    logic               resp_hit, bypass, push, pop;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign resp_hit = (state == RESP) && mem_rvalid && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_hit && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word consumed the same cycle never occupies a slot
    assign push       = resp_hit && !(bypass && out_ready);
    assign pop        = (count != '0) && out_ready && !redirect;
    assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    assign out_valid = ((count != '0) || bypass) && !redirect;
    assign inst      = bypass ? mem_rdata : fifo_inst[rd_ptr];
    assign pc_addr   = bypass ? issued_pc : fifo_pc[rd_ptr];
    assign mem_req   = (state == REQ);
    assign mem_addr  = fetch_pc;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        if (redirect) begin
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
        end
        case (state)
            IDLE: begin
                if (!redirect && (count < DEPTH_CNT)) state_next = REQ;
            end
            REQ: begin
                if (redirect) begin
                    state_next = mem_gnt ? DROP : IDLE;
                end else if (mem_gnt) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = RESP;
                end
            end
            RESP: begin
                if (redirect) begin
                    state_next = mem_rvalid ? IDLE : DROP;
                end else if (mem_rvalid) begin
                    state_next = (count_next < DEPTH_CNT) ? REQ : IDLE;
                end
            end
            DROP: begin
                // The stale response retires the outstanding transaction even if a
                // new redirect lands on the same cycle; nothing else is pending.
                if (mem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            issued_pc <= 32'h0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= 32'h0;
                fifo_pc[i]   <= 32'h0;
            end
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if ((state == REQ) && mem_gnt) begin
                issued_pc <= fetch_pc;
            end
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo_inst[wr_ptr] <= mem_rdata;
                    fifo_pc[wr_ptr]   <= issued_pc;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_fetch_queue                                                        |
// | Directed vector table, corner sequences and randomized traffic against a   |
// | transaction-level model of the fetch stream.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] SENT     = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_gnt, mem_rvalid, redirect, out_valid, out_ready;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, inst, pc_addr;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .inst(inst), .pc_addr(pc_addr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic gnt; logic rvalid; logic [31:0] rdata; logic redir; logic [31:0] rpc; logic rdy;
        logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc; logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic rr, input logic [31:0] rp, input logic ry,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redir = rr; v.rpc = rp; v.rdy = ry;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    // ---------------- transaction-level reference model ----------------
    typedef struct packed { logic [31:0] pc; logic [31:0] word; } ent_t;
    ent_t        q[$];
    logic [31:0] grant_log[$];
    logic [31:0] exp_fetch, resp_addr, prev_addr, post_grant, post_pop;
    bit          outstanding, stale, prev_req, prev_gnt, prev_redir;
    bit          redir_on_resp, redir_on_rvalid, track_grant, track_pop;
    logic [31:0] forced_pc;
    int          resp_cnt, grants, pops;
    int          gnt_pct = 100, lat_min = 0, lat_max = 0, ready_pct = 100, redir_pct = 0;

    task automatic model_reset();
        q.delete(); grant_log.delete();
        exp_fetch = RESET_PC; outstanding = 0; stale = 0; resp_cnt = 0;
        prev_req = 0; prev_gnt = 0; prev_redir = 0; prev_addr = 32'h0;
        grants = 0; pops = 0; track_grant = 0; track_pop = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        redirect = 0; redirect_pc = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One clock: drive memory/decoder/redirect at posedge+1, check and advance model at negedge.
    task automatic step();
        bit forced_now = 0;
        bit do_pop, do_push;
        @(posedge clk); #1;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0; redirect = 0;
        redirect_pc = $urandom();
        out_ready = (int'($urandom_range(99)) < ready_pct);
        if (outstanding && resp_cnt == 0) begin
            mem_rvalid = 1; mem_rdata = word_of(resp_addr);
        end
        if (mem_req) mem_gnt = (int'($urandom_range(99)) < gnt_pct);
        if (int'($urandom_range(99)) < redir_pct) begin
            redirect = 1;
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
        end
        if (redir_on_resp && outstanding && !stale && !mem_rvalid) begin
            redirect = 1; redirect_pc = forced_pc; redir_on_resp = 0; forced_now = 1;
        end
        if (redir_on_rvalid && mem_rvalid && !stale && q.size() != 0) begin
            redirect = 1; redirect_pc = forced_pc; out_ready = 1; redir_on_rvalid = 0; forced_now = 1;
        end
        @(negedge clk);
        if (prev_req && !prev_gnt && !prev_redir) begin
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("addr_hold", mem_addr, prev_addr);
        end
        if (mem_req) chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
        chk("req_while_busy", 32'(mem_req && outstanding), 32'd0);
        chk("out_valid", 32'(out_valid), 32'((q.size() != 0) && !redirect));
        if (out_valid && q.size() != 0) begin
            chk("pc_addr", pc_addr, q[0].pc);
            chk("inst", inst, q[0].word);
        end
        do_pop  = out_valid && out_ready && !redirect && (q.size() != 0);
        do_push = 0;
        if (mem_req && mem_gnt) begin
            chk("fetch_addr", mem_addr, exp_fetch);
            exp_fetch += 32'd4; grants++; grant_log.push_back(mem_addr);
            if (track_grant) begin post_grant = mem_addr; track_grant = 0; end
            outstanding = 1; stale = redirect; resp_addr = mem_addr;
            resp_cnt = int'($urandom_range(lat_max, lat_min));
        end else if (outstanding) begin
            if (mem_rvalid) begin
                outstanding = 0;
                if (!stale && !redirect) begin
                    chk("space_reserved", 32'(q.size() < DEPTH), 32'd1);
                    do_push = 1;
                end
            end else begin
                resp_cnt--;
                if (redirect) stale = 1;
            end
        end
        if (do_pop) begin
            if (track_pop) begin post_pop = q[0].pc; track_pop = 0; end
            pops++;
            void'(q.pop_front());
        end
        if (do_push) q.push_back('{resp_addr, word_of(resp_addr)});
        if (redirect) begin
            q.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
        end
        if (forced_now) begin
            track_grant = 1; track_pop = 1; post_grant = SENT; post_pop = SENT;
        end
        prev_req = mem_req; prev_gnt = mem_gnt; prev_redir = redirect; prev_addr = mem_addr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[14];
        int   g0, p0;
        vt[0]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,   1'b0, 1'b0,32'h0,   1'b0,32'h0,   32'h0);
        vt[1]  = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,   1'b1, 1'b1,32'h0,   1'b0,32'h0,   32'h0);
        vt[2]  = mk(1'b0,1'b1,32'h1111_0000,1'b0,32'h0,   1'b1, 1'b0,32'h4,   1'b0,32'h0,   32'h0);
        vt[3]  = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,   1'b1, 1'b1,32'h4,   1'b1,32'h0,   32'h1111_0000);
        vt[4]  = mk(1'b0,1'b1,32'h2222_0004,1'b0,32'h0,   1'b1, 1'b0,32'h8,   1'b0,32'h0,   32'h0);
        vt[5]  = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,   1'b0, 1'b1,32'h8,   1'b1,32'h4,   32'h2222_0004);
        vt[6]  = mk(1'b0,1'b1,32'h3333_0008,1'b0,32'h0,   1'b0, 1'b0,32'hC,   1'b1,32'h4,   32'h2222_0004);
        vt[7]  = mk(1'b0,1'b0,32'h0,        1'b1,32'h1003,1'b1, 1'b1,32'hC,   1'b0,32'h0,   32'h0);
        vt[8]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,   1'b1, 1'b0,32'h1000,1'b0,32'h0,   32'h0);
        vt[9]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,   1'b1, 1'b1,32'h1000,1'b0,32'h0,   32'h0);
        vt[10] = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,   1'b1, 1'b1,32'h1000,1'b0,32'h0,   32'h0);
        vt[11] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,   1'b1, 1'b0,32'h1004,1'b0,32'h0,   32'h0);
        vt[12] = mk(1'b0,1'b1,32'h4444_1000,1'b0,32'h0,   1'b1, 1'b0,32'h1004,1'b0,32'h0,   32'h0);
        vt[13] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,   1'b1, 1'b1,32'h1004,1'b1,32'h1000,32'h4444_1000);

        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; redirect = 0; redirect_pc = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            mem_gnt = vt[i].gnt; mem_rvalid = vt[i].rvalid; mem_rdata = vt[i].rdata;
            redirect = vt[i].redir; redirect_pc = vt[i].rpc; out_ready = vt[i].rdy;
            if (i > 0) @(negedge clk); else #1;
            chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vt[i].e_req));
            chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), pc_addr, vt[i].e_pc);
                chk($sformatf("vec%0d_inst", i), inst, vt[i].e_inst);
            end
        end

        // Fill with decoder stalled, then drain and resume.
        do_reset();
        gnt_pct = 100; lat_min = 0; lat_max = 0; ready_pct = 0; redir_pct = 0;
        repeat (12) step();
        chk("fill_grants", 32'(grants), 32'(DEPTH));
        chk("fill_req_low", 32'(mem_req), 32'd0);
        chk("fill_valid", 32'(out_valid), 32'd1);
        ready_pct = 100;
        repeat (12) step();
        chk("drain_pops", 32'(pops >= DEPTH), 32'd1);
        chk("resume_addr", (grant_log.size() > DEPTH) ? grant_log[DEPTH] : SENT, 32'h10);

        // Grant withheld for five cycles.
        gnt_pct = 0;
        for (int k = 0; k < 20 && !mem_req; k++) step();
        g0 = grants;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("gnt_wait_req", 32'(mem_req), 32'd1);
        end
        gnt_pct = 100;
        step();
        chk("gnt_wait_one_grant", 32'(grants - g0), 32'd1);

        // Redirect while a response is pending; stale word arrives three cycles later.
        lat_min = 3; lat_max = 3; forced_pc = 32'h1003; redir_on_resp = 1;
        post_grant = SENT; post_pop = SENT;
        repeat (30) step();
        chk("redir_resp_fired", 32'(redir_on_resp), 32'd0);
        chk("redir_resp_grant", post_grant, 32'h1000);
        chk("redir_resp_first_pc", post_pop, 32'h1000);

        // Redirect coinciding with a decoder handshake and a response.
        lat_min = 1; lat_max = 1; ready_pct = 0; forced_pc = 32'h2000; redir_on_rvalid = 1;
        post_grant = SENT; post_pop = SENT;
        for (int k = 0; k < 40 && redir_on_rvalid; k++) step();
        chk("redir_same_fired", 32'(redir_on_rvalid), 32'd0);
        step();
        chk("redir_same_valid_next", 32'(out_valid), 32'd0);
        ready_pct = 100;
        repeat (12) step();
        chk("redir_same_first_pc", post_pop, 32'h2000);

        // Randomized traffic.
        p0 = pops;
        for (int r = 0; r < 6; r++) begin
            gnt_pct   = int'($urandom_range(100, 30));
            lat_min   = 0;
            lat_max   = int'($urandom_range(4, 0));
            ready_pct = int'($urandom_range(100, 20));
            redir_pct = int'($urandom_range(5, 0));
            repeat (500) step();
        end
        chk("random_progress", 32'(pops > p0 + 100), 32'd1);

        // Asynchronous reset mid-response with two entries queued.
        redir_pct = 0;
        do_reset();
        gnt_pct = 100; lat_min = 2; lat_max = 2; ready_pct = 0;
        for (int k = 0; k < 60 && !(q.size() == 2 && outstanding); k++) step();
        chk("rst_setup_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; out_ready = 1'b0; mem_gnt = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, RESET_PC);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", pc_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk("late_rvalid_ignored", 32'(out_valid), 32'd0);
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", mem_addr, RESET_PC);
        lat_min = 0; lat_max = 0; ready_pct = 100;
        repeat (10) step();
        chk("restart_progress", 32'(pops > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
